// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and default widths shared by the ALU sequencer slice
package alu_pkg;
  localparam int DEF_INPUT_WIDTH = 4;
  localparam int DEF_OUTPUT_WIDTH = 8;
  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_MUL = 3'b011,
    OP_LSH = 3'b100,
    OP_RSH = 3'b101,
    OP_AND = 3'b110,
    OP_OR  = 3'b111
  } opcode_t;
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_MUL  = 2'b10
  } state_t;
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request/operand and completion/result signals of the ALU sequencer
interface alu_sequencer_if import alu_pkg::*; #(
  parameter int INPUT_WIDTH = DEF_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH
);
  logic start;
  opcode_t opcode;
  logic [INPUT_WIDTH-1:0] a;
  logic [INPUT_WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [OUTPUT_WIDTH-1:0] result;
  logic ldo;
  logic flag;
  modport master (output start, opcode, a, b, input busy, done, result, ldo, flag);
  modport slave (input start, opcode, a, b, output busy, done, result, ldo, flag);
endinterface

// File: rtl/mul_datapath.sv
// mul_datapath: radix-2 shift-add multiplier, one multiplier bit per step
module mul_datapath import alu_pkg::*; #(
  parameter int INPUT_WIDTH = DEF_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH
) (
  input logic clk,
  input logic reset,
  input logic load,
  input logic step,
  input logic [INPUT_WIDTH-1:0] a,
  input logic [INPUT_WIDTH-1:0] b,
  output logic [OUTPUT_WIDTH-1:0] prod,
  output logic last
);
  logic [OUTPUT_WIDTH-1:0] acc, mcand;
  logic [INPUT_WIDTH-1:0] mplier;
  logic [1:0] cnt;
  // prod already includes the current bit, so the last step's prod is the final product
  assign prod = acc + (mplier[0] ? mcand : '0);
  assign last = cnt == 2'(INPUT_WIDTH - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
    end else if (load) begin
      acc <= '0;
      mcand <= OUTPUT_WIDTH'(a);
      mplier <= b;
      cnt <= '0;
    end else if (step) begin
      acc <= prod;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 2'd1;
    end
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: single-issue ALU with one-cycle ops and a multi-cycle shift-add multiply
module alu_sequencer import alu_pkg::*; #(
  parameter int INPUT_WIDTH = DEF_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH
) (
  input logic clk,
  input logic reset,
  alu_sequencer_if.slave bus
);
  state_t state, state_nx;
  opcode_t op_q;
  logic [INPUT_WIDTH-1:0] a_q, b_q, diff;
  logic [INPUT_WIDTH:0] sum;
  logic [OUTPUT_WIDTH-1:0] result_q, res_nx, prod;
  logic flag_q, flag_nx, done_q, ldo_q, accept, last, fin;
  assign accept = state == S_IDLE && bus.start;
  assign fin = state == S_EXEC || (state == S_MUL && last);
  assign sum = {1'b0, a_q} + {1'b0, b_q};
  assign diff = a_q - b_q;
  mul_datapath #(.INPUT_WIDTH(INPUT_WIDTH), .OUTPUT_WIDTH(OUTPUT_WIDTH)) u_mul (
    .clk(clk),
    .reset(reset),
    .load(accept),
    .step(state == S_MUL),
    .a(bus.a),
    .b(bus.b),
    .prod(prod),
    .last(last)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    state_nx = state == S_IDLE ? (bus.start ? (bus.opcode == OP_MUL ? S_MUL : S_EXEC) : S_IDLE)
             : (state == S_MUL && !last) ? S_MUL : S_IDLE;
  end
  always_comb begin
    res_nx = result_q;
    flag_nx = flag_q;
    case (op_q)
      OP_ADD: begin res_nx = OUTPUT_WIDTH'(sum); flag_nx = sum[INPUT_WIDTH]; end
      OP_SUB: begin res_nx = OUTPUT_WIDTH'(diff); flag_nx = a_q < b_q; end
      OP_MUL: begin res_nx = prod; flag_nx = 1'b0; end
      OP_LSH: begin res_nx = OUTPUT_WIDTH'({a_q, 1'b0}); flag_nx = 1'b0; end
      OP_RSH: begin res_nx = OUTPUT_WIDTH'(a_q >> 1); flag_nx = a_q[0]; end
      OP_AND: begin res_nx = OUTPUT_WIDTH'(a_q & b_q); flag_nx = 1'b0; end
      OP_OR:  begin res_nx = OUTPUT_WIDTH'(a_q | b_q); flag_nx = 1'b0; end
      default: begin res_nx = result_q; flag_nx = flag_q; end
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q <= OP_NOP;
      a_q <= '0;
      b_q <= '0;
      result_q <= '0;
      flag_q <= 1'b0;
      done_q <= 1'b0;
      ldo_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= bus.opcode;
        a_q <= bus.a;
        b_q <= bus.b;
      end
      done_q <= fin;
      ldo_q <= fin && op_q != OP_NOP;
      if (fin) begin
        result_q <= res_nx;
        flag_q <= flag_nx;
      end
    end
  end
  assign bus.busy = state != S_IDLE;
  assign bus.done = done_q;
  assign bus.ldo = ldo_q;
  assign bus.result = result_q;
  assign bus.flag = flag_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed scoreboard bench for alu_sequencer
module tb_alu_sequencer;
  import alu_pkg::*;
  typedef struct {
    logic [7:0] res;
    logic flag;
    logic ldo;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errs = 0;
  int checks = 0;
  string tname = "init";
  exp_t sb[$];
  logic [7:0] last_res = 8'h00;
  logic last_flag = 1'b0;
  alu_sequencer_if #(.INPUT_WIDTH(4), .OUTPUT_WIDTH(8)) bus ();
  alu_sequencer #(.INPUT_WIDTH(4), .OUTPUT_WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s/%s: observed=%0h expected=%0h", tname, tag, got, exp);
    end
  endtask
  task automatic push(input opcode_t op, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    logic [7:0] r;
    logic f;
    r = last_res;
    f = last_flag;
    case (op)
      OP_ADD: begin r = {4'h0, a} + {4'h0, b}; f = r[4]; end
      OP_SUB: begin r = {4'h0, 4'(a - b)}; f = a < b; end
      OP_MUL: begin r = {4'h0, a} * {4'h0, b}; f = 1'b0; end
      OP_LSH: begin r = {3'b000, a, 1'b0}; f = 1'b0; end
      OP_RSH: begin r = {5'b00000, a[3:1]}; f = a[0]; end
      OP_AND: begin r = {4'h0, a & b}; f = 1'b0; end
      OP_OR:  begin r = {4'h0, a | b}; f = 1'b0; end
      default: begin r = last_res; f = last_flag; end
    endcase
    e.res = r;
    e.flag = f;
    e.ldo = op != OP_NOP;
    last_res = r;
    last_flag = f;
    sb.push_back(e);
  endtask
  task automatic issue(input opcode_t op, input logic [3:0] a, input logic [3:0] b);
    bus.start = 1'b1;
    bus.opcode = op;
    bus.a = a;
    bus.b = b;
    tick();
    bus.start = 1'b0;
    bus.opcode = opcode_t'($urandom_range(7));
    bus.a = 4'($urandom);
    bus.b = 4'($urandom);
    chk("accepted_busy", bus.busy, 1);
    chk("done_one_cycle", bus.done, 0);
  endtask
  task automatic wait_done(input int lat);
    int n = 0;
    int bc = 0;
    exp_t e;
    while (bus.done !== 1'b1 && n < 20) begin
      if (bus.busy === 1'b1) bc++;
      tick();
      n++;
    end
    chk("latency", n, lat);
    chk("busy_cycles", bc, lat);
    chk("busy_at_done", bus.busy, 0);
    chk("sb_size", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("result", bus.result, e.res);
      chk("flag", bus.flag, e.flag);
      chk("ldo", bus.ldo, e.ldo);
    end
  endtask
  initial begin
    int dn;
    bus.start = 1'b0;
    bus.opcode = OP_NOP;
    bus.a = 4'h0;
    bus.b = 4'h0;
    #2 reset = 1'b0;
    #1;
    tname = "reset";
    chk("busy", bus.busy, 0);
    chk("done", bus.done, 0);
    chk("ldo", bus.ldo, 0);
    chk("result", bus.result, 0);
    chk("flag", bus.flag, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    tname = "add_9_8";   push(OP_ADD, 4'd9, 4'd8);   issue(OP_ADD, 4'd9, 4'd8);   wait_done(1);
    tname = "sub_3_5";   push(OP_SUB, 4'd3, 4'd5);   issue(OP_SUB, 4'd3, 4'd5);   wait_done(1);
    tname = "sub_5_3";   push(OP_SUB, 4'd5, 4'd3);   issue(OP_SUB, 4'd5, 4'd3);   wait_done(1);
    tname = "rsh_5";     push(OP_RSH, 4'd5, 4'd0);   issue(OP_RSH, 4'd5, 4'd0);   wait_done(1);
    tname = "lsh_f";     push(OP_LSH, 4'hF, 4'd0);   issue(OP_LSH, 4'hF, 4'd0);   wait_done(1);
    tname = "and_c_a";   push(OP_AND, 4'hC, 4'hA);   issue(OP_AND, 4'hC, 4'hA);   wait_done(1);
    tname = "or_c_a";    push(OP_OR, 4'hC, 4'hA);    issue(OP_OR, 4'hC, 4'hA);    wait_done(1);
    tname = "mul_15_15"; push(OP_MUL, 4'd15, 4'd15); issue(OP_MUL, 4'd15, 4'd15); wait_done(4);
    tname = "mul_0_7";   push(OP_MUL, 4'd0, 4'd7);   issue(OP_MUL, 4'd0, 4'd7);   wait_done(4);
    tname = "mul_busy";
    push(OP_MUL, 4'd3, 4'd4);
    issue(OP_MUL, 4'd3, 4'd4);
    bus.start = 1'b1;
    bus.opcode = OP_ADD;
    bus.a = 4'd1;
    bus.b = 4'd1;
    tick();
    bus.start = 1'b0;
    wait_done(3);
    tname = "nop";
    push(OP_NOP, 4'd0, 4'd0);
    issue(OP_NOP, 4'd0, 4'd0);
    wait_done(1);
    dn = 0;
    repeat (5) begin
      tick();
      if (bus.done === 1'b1) dn++;
    end
    chk("no_extra_done", dn, 0);
    chk("result_hold", bus.result, 8'h0C);
    tname = "rst_mid_mul";
    issue(OP_MUL, 4'd15, 4'd15);
    tick();
    reset = 1'b0;
    #1;
    chk("busy", bus.busy, 0);
    chk("done", bus.done, 0);
    chk("ldo", bus.ldo, 0);
    chk("result", bus.result, 0);
    chk("flag", bus.flag, 0);
    last_res = 8'h00;
    last_flag = 1'b0;
    dn = 0;
    repeat (4) begin
      tick();
      if (bus.done === 1'b1 || bus.ldo === 1'b1) dn++;
    end
    reset = 1'b1;
    tick();
    chk("no_done_after_abort", dn, 0);
    tname = "add_1_1";
    push(OP_ADD, 4'd1, 4'd1);
    issue(OP_ADD, 4'd1, 4'd1);
    wait_done(1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter INPUT_WIDTH, default 4, operand width.
REQ-002 The block SHALL have parameter OUTPUT_WIDTH, default 8, result width (2*INPUT_WIDTH).
REQ-003 The block SHALL have port clk input 1: single clock, all state on rising edge.
REQ-004 The block SHALL have port reset input 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port start input 1: request to execute one operation.
REQ-006 The block SHALL have port opcode input 3: operation select, sampled with start.
REQ-007 The block SHALL have ports a and b, each input INPUT_WIDTH: operands from the A/B register outputs, sampled with start.
REQ-008 The block SHALL have port busy output 1: high while an accepted operation is in flight.
REQ-009 The block SHALL have port done output 1: one-cycle completion pulse.
REQ-010 The block SHALL have port result output OUTPUT_WIDTH: value driven onto the O register input.
REQ-011 The block SHALL have port ldo output 1: one-cycle load strobe for the O register.
REQ-012 The block SHALL have port flag output 1: carry, borrow or underflow of the last operation.

Function
REQ-013 Opcodes SHALL be decoded as follows: 000 NOP, 001 ADD, 010 SUB, 011 MUL, 100 LSH, 101 RSH, 110 AND, 111 OR.
REQ-014 The FSM SHALL have the states IDLE, EXEC and MUL, with busy = (state != IDLE).
REQ-015 The block SHALL accept start only in IDLE; on that edge it captures a, b and opcode, then goes to MUL if opcode=MUL and to EXEC otherwise.
REQ-016 A start asserted while busy SHALL be ignored and SHALL NOT be queued.
REQ-017 EXEC SHALL take one cycle: on the next edge it writes result and flag, pulses done, and returns to IDLE.
REQ-018 MUL SHALL perform radix-2 shift-add, one multiplier bit per cycle, INPUT_WIDTH iterations with a 2-bit iteration counter: on the last iteration edge it writes result and flag, pulses done, and returns to IDLE.
REQ-019 Latency from the start-sampling edge to done high SHALL be 1 cycle for non-MUL opcodes and INPUT_WIDTH cycles (4) for MUL.
REQ-020 done and ldo SHALL each be high for exactly one cycle per accepted operation, with ldo = done AND opcode != NOP.
REQ-021 NOP SHALL pulse done without asserting ldo and SHALL leave result and flag unchanged.
REQ-022 ADD SHALL produce result = zero-extended a + b, flag = result[INPUT_WIDTH] (carry).
REQ-023 SUB SHALL produce result = zero-extended (a - b) mod 2^INPUT_WIDTH, flag = (a < b) (borrow).
REQ-024 MUL SHALL produce result = a * b (full 8 bits, no overflow possible), flag = 0.
REQ-025 LSH SHALL produce result = zero-extended a << 1 (bit INPUT_WIDTH retained), flag = 0.
REQ-026 RSH SHALL produce result = zero-extended a >> 1, flag = a[0] (underflow).
REQ-027 AND and OR SHALL produce the bitwise result zero-extended, flag = 0.
REQ-028 result and flag SHALL hold their value between operations.
REQ-029 A start asserted in the cycle where done is high SHALL be accepted (state is IDLE), giving back-to-back operations with no gap.
REQ-030 Operand or opcode changes after the capture edge SHALL NOT affect an in-flight operation.

Reset
REQ-031 Asserting reset low SHALL immediately force state=IDLE and result=0, flag=0, done=0, ldo=0, busy=0, and clear the counter, accumulator and captured operands.
REQ-032 Reset asserted mid-MUL SHALL abort the operation with no done or ldo pulse; the first start after release SHALL begin a fresh operation.

Structure
REQ-033 A shared package alu_pkg SHALL hold the opcode constants, the FSM state encoding and the default widths.
REQ-034 The shift-add datapath (accumulator, shifted multiplicand, counter) SHALL be one sub-module named mul_datapath, controlled by alu_sequencer; all other logic SHALL be inline.

Verification
REQ-035 The bench SHALL check ADD: a=9, b=8, start for 1 cycle -> done high 1 cycle later, result=0x11, flag=1, ldo=1 for one cycle.
REQ-036 The bench SHALL check SUB: a=3, b=5 -> result=0x0E, flag=1; a=5, b=3 -> result=0x02, flag=0.
REQ-037 The bench SHALL check MUL: a=15, b=15 -> busy high 4 cycles, done on the 4th, result=0xE1, flag=0; a=0, b=7 -> result=0x00.
REQ-038 The bench SHALL check RSH and LSH: RSH a=5 -> result=0x02, flag=1; LSH a=0xF -> result=0x1E, flag=0.
REQ-039 The bench SHALL check that start during busy and NOP are handled: MUL 3*4 in flight, second start with ADD -> ignored, single done, result=0x0C; then NOP -> done pulse, ldo=0, result stays 0x0C.
REQ-040 The bench SHALL check reset mid-MUL: reset low at iteration 2 -> all outputs 0 at once, no done; after release, ADD 1+1 -> result=0x02.
